window_gen: RTL and testbench

- Streaming front end for nn_block: accepts raster-order image pixels, one per handshake.
- Holds K_SIZE-1 line buffers plus a K_SIZE x K_SIZE shift window.
- Emits every valid (no-padding) K_SIZE x K_SIZE window in the windowImg format that conv2d consumes, under a ready/valid handshake with row/column tags and an end-of-frame marker.

---
 rtl/window_gen_if.sv | 35 +++
 rtl/window_gen.sv | 113 +++++++++++
 tb/tb_window_gen.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/window_gen_if.sv
// window_gen_if: pixel-in / window-out handshake bundle for window_gen.
//   slave  : view used by window_gen (accepts pixels, produces windows)
//   master : view used by the pixel source / window consumer
// Signals:
//   in_valid, in_ready, in_data        pixel stream, raster order
//   win_valid, win_ready               window handshake
//   windowImg[r][c]                    window, r=0 top row, c=0 left column
//   win_row, win_col                   top-left coordinate of the window
//   win_last                           last window of the frame
interface window_gen_if #(
    parameter int K_SIZE = 3,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int PIX_W  = 9
);
    logic                            in_valid;
    logic                            in_ready;
    logic signed [PIX_W-1:0]         in_data;
    logic                            win_valid;
    logic                            win_ready;
    logic signed [PIX_W-1:0]         windowImg [0:K_SIZE-1][0:K_SIZE-1];
    logic [$clog2(IMG_H)-1:0]        win_row;
    logic [$clog2(IMG_W)-1:0]        win_col;
    logic                            win_last;

    modport slave (
        input  in_valid, in_data, win_ready,
        output in_ready, win_valid, windowImg, win_row, win_col, win_last
    );

    modport master (
        output in_valid, in_data, win_ready,
        input  in_ready, win_valid, windowImg, win_row, win_col, win_last
    );
endinterface

// File: rtl/window_gen.sv
// window_gen: sliding K_SIZE x K_SIZE window generator over a raster pixel
// stream. Keeps K_SIZE-1 line buffers and a shift window; every accepted
// pixel whose window lies fully inside the image produces one window on the
// next cycle.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   window_gen_if.slave (pixel input and window output handshakes)
module window_gen #(
    parameter int K_SIZE = 3,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int PIX_W  = 9
) (
    input  logic          clk,
    input  logic          rst,
    window_gen_if.slave   bus
);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    localparam logic [ROW_W-1:0] ROW_EMIT = ROW_W'(K_SIZE - 1);
    localparam logic [COL_W-1:0] COL_EMIT = COL_W'(K_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

    // r_line[0] is the most recent row, r_line[K_SIZE-2] the oldest.
    logic signed [PIX_W-1:0] r_line [0:K_SIZE-2][0:IMG_W-1];
    logic signed [PIX_W-1:0] r_win  [0:K_SIZE-1][0:K_SIZE-1];

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             r_win_valid;
    logic [ROW_W-1:0] r_win_row;
    logic [COL_W-1:0] r_win_col;
    logic             r_win_last;

    logic w_in_ready;
    logic w_accept;
    logic w_emit;
    logic w_last_pix;

    always_comb begin
        w_in_ready = rst && (!r_win_valid || bus.win_ready);
        w_accept   = bus.in_valid && w_in_ready;
        w_emit     = w_accept && (r_row >= ROW_EMIT) && (r_col >= COL_EMIT);
        w_last_pix = (r_row == ROW_LAST) && (r_col == COL_LAST);
    end

    // Line buffers hold no control state, so they are left out of reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int j = 1; j <= K_SIZE - 2; j++) begin
                r_line[j][r_col] <= r_line[j-1][r_col];
            end
            r_line[0][r_col] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_row       <= '0;
            r_col       <= '0;
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
            r_win_last  <= 1'b0;
            for (int r = 0; r < K_SIZE; r++) begin
                for (int c = 0; c < K_SIZE; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else begin
            if (w_accept) begin
                for (int r = 0; r < K_SIZE; r++) begin
                    for (int c = 0; c < K_SIZE - 1; c++) begin
                        r_win[r][c] <= r_win[r][c+1];
                    end
                end
                // New right column: buffered rows oldest-on-top, live pixel at the bottom.
                for (int r = 0; r < K_SIZE - 1; r++) begin
                    r_win[r][K_SIZE-1] <= r_line[K_SIZE-2-r][r_col];
                end
                r_win[K_SIZE-1][K_SIZE-1] <= bus.in_data;

                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            // The shift window itself is the output register; it only moves
            // on an accept, which cannot happen while a window is stalled.
            if (w_emit) begin
                r_win_valid <= 1'b1;
                r_win_row   <= r_row - ROW_EMIT;
                r_win_col   <= r_col - COL_EMIT;
                r_win_last  <= w_last_pix;
            end else if (bus.win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.win_valid = r_win_valid;
    assign bus.windowImg = r_win;
    assign bus.win_row   = r_win_row;
    assign bus.win_col   = r_win_col;
    assign bus.win_last  = r_win_last;
endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen: randomized stimulus against an image-array reference model
// for window_gen (5x4 image, 3x3 window).
module tb_window_gen;
    localparam int K  = 3;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = 9;

    typedef struct packed {
        logic [K*K*PW-1:0] px;
        int                row;
        int                col;
        logic              last;
    } win_t;

    logic clk;
    logic rst;

    window_gen_if #(.K_SIZE(K), .IMG_W(W), .IMG_H(H), .PIX_W(PW)) u_if ();

    window_gen #(.K_SIZE(K), .IMG_W(W), .IMG_H(H), .PIX_W(PW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   img [0:H-1][0:W-1];
    int   mr = 0;
    int   mc = 0;
    win_t exp_q [$];
    win_t got_q [$];
    int   n_win  = 0;
    int   n_last = 0;
    int   stim [$];

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: every accepted pixel is written into a full image array; a
    // window is the KxK block of that array ending at the pixel.
    always @(negedge clk) begin
        win_t e;
        win_t g;
        int   exp_rdy;
        check_val("win_valid", int'(u_if.win_valid), int'(exp_q.size() != 0));
        exp_rdy = int'(rst && (exp_q.size() == 0 || u_if.win_ready));
        check_val("in_ready", int'(u_if.in_ready), exp_rdy);
        if (exp_q.size() != 0 && u_if.win_valid) begin
            e = exp_q[0];
            check_val("win_row", int'(u_if.win_row), e.row);
            check_val("win_col", int'(u_if.win_col), e.col);
            check_val("win_last", int'(u_if.win_last), int'(e.last));
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    check_val($sformatf("px[%0d][%0d]", r, c), int'(u_if.windowImg[r][c]),
                              int'($signed(e.px[(r*K+c)*PW +: PW])));
        end
        if (!rst) begin
            exp_q.delete();
            mr = 0;
            mc = 0;
        end else begin
            if (u_if.win_valid && u_if.win_ready && exp_q.size() != 0) begin
                g.px   = '0;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        g.px[(r*K+c)*PW +: PW] = u_if.windowImg[r][c];
                g.row  = int'(u_if.win_row);
                g.col  = int'(u_if.win_col);
                g.last = u_if.win_last;
                got_q.push_back(g);
                if (exp_q[0].last) n_last++;
                n_win++;
                void'(exp_q.pop_front());
            end
            if (u_if.in_valid && u_if.in_ready) begin
                img[mr][mc] = int'(u_if.in_data);
                if (mr >= K-1 && mc >= K-1) begin
                    e.px = '0;
                    for (int r = 0; r < K; r++)
                        for (int c = 0; c < K; c++)
                            e.px[(r*K+c)*PW +: PW] = PW'(img[mr-K+1+r][mc-K+1+c]);
                    e.row  = mr - K + 1;
                    e.col  = mc - K + 1;
                    e.last = (mr == H-1) && (mc == W-1);
                    exp_q.push_back(e);
                end
                mc++;
                if (mc == W) begin
                    mc = 0;
                    mr = (mr == H-1) ? 0 : mr + 1;
                end
            end
        end
    end

    task automatic run_stream(input int gap_pct, input int rdy_pct, input bit bp_en);
        int cyc = 0;
        bit acc;
        int bp_cnt = 0;
        bit bp_done = 0;
        while (stim.size() != 0 && cyc < 2000) begin
            if (bp_en && !bp_done && u_if.win_valid) begin
                bp_cnt  = 5;
                bp_done = 1;
            end
            u_if.win_ready = (bp_cnt > 0) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            if (bp_cnt > 0) bp_cnt--;
            if ($urandom_range(99) >= gap_pct) begin
                u_if.in_valid = 1'b1;
                u_if.in_data  = PW'(stim[0]);
            end else begin
                u_if.in_valid = 1'b0;
                u_if.in_data  = PW'($urandom);
            end
            @(negedge clk);
            acc = u_if.in_valid && u_if.in_ready;
            @(posedge clk);
            #1;
            if (acc) void'(stim.pop_front());
            cyc++;
        end
        check_val("stream_consumed", stim.size(), 0);
        u_if.in_valid  = 1'b0;
        u_if.win_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_val("drain", exp_q.size(), 0);
    endtask

    task automatic load_ramp(input int frames);
        stim.delete();
        for (int f = 0; f < frames; f++)
            for (int i = 0; i < W*H; i++) stim.push_back(i);
    endtask

    // Window at (wr,wc) of the ramp image row*W+col.
    task automatic check_ramp_win(input string tag, input int idx, input int wr, input int wc, input bit last);
        if (got_q.size() > idx) begin
            check_val({tag, "_row"}, got_q[idx].row, wr);
            check_val({tag, "_col"}, got_q[idx].col, wc);
            check_val({tag, "_last"}, int'(got_q[idx].last), int'(last));
            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    check_val($sformatf("%s_px%0d%0d", tag, r, c),
                              int'($signed(got_q[idx].px[(r*K+c)*PW +: PW])), (wr+r)*W + wc + c);
        end else begin
            check_val({tag, "_present"}, got_q.size(), idx + 1);
        end
    endtask

    task automatic start_test();
        n_win  = 0;
        n_last = 0;
        got_q.delete();
    endtask

    initial begin
        rst            = 1'b0;
        u_if.in_valid  = 1'b0;
        u_if.in_data   = '0;
        u_if.win_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_win_valid", int'(u_if.win_valid), 0);
        check_val("rst_win_last", int'(u_if.win_last), 0);
        check_val("rst_win_row", int'(u_if.win_row), 0);
        check_val("rst_win_col", int'(u_if.win_col), 0);
        check_val("rst_px11", int'(u_if.windowImg[1][1]), 0);
        check_val("rst_in_ready", int'(u_if.in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Ramp frame, full throughput.
        start_test();
        load_ramp(1);
        run_stream(0, 100, 1'b0);
        check_val("t1_nwin", n_win, 6);
        check_val("t1_nlast", n_last, 1);
        check_ramp_win("t1_first", 0, 0, 0, 1'b0);
        check_ramp_win("t1_final", 5, 1, 2, 1'b1);

        // Backpressure on the first window.
        start_test();
        load_ramp(1);
        run_stream(0, 100, 1'b1);
        check_val("t2_nwin", n_win, 6);
        check_ramp_win("t2_first", 0, 0, 0, 1'b0);
        check_ramp_win("t2_final", 5, 1, 2, 1'b1);

        // Sign extremes.
        start_test();
        stim.delete();
        for (int i = 0; i < W*H; i++) stim.push_back((i % 2) ? 255 : -256);
        run_stream(0, 100, 1'b0);
        check_val("t3_nwin", n_win, 6);
        if (got_q.size() > 0) begin
            check_val("t3_px00", int'($signed(got_q[0].px[0 +: PW])), -256);
            check_val("t3_px01", int'($signed(got_q[0].px[PW +: PW])), 255);
        end

        // Two frames back to back.
        start_test();
        load_ramp(2);
        run_stream(0, 100, 1'b0);
        check_val("t4_nwin", n_win, 12);
        check_val("t4_nlast", n_last, 2);
        check_ramp_win("t4_f2first", 6, 0, 0, 1'b0);

        // Random input gaps and random output stalls.
        start_test();
        load_ramp(2);
        run_stream(40, 70, 1'b0);
        check_val("t5_nwin", n_win, 12);
        check_ramp_win("t5_first", 0, 0, 0, 1'b0);
        check_ramp_win("t5_final", 11, 1, 2, 1'b1);

        // Reset mid-frame after pixel 8.
        start_test();
        stim.delete();
        for (int i = 0; i < 9; i++) stim.push_back(i);
        run_stream(0, 100, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_val("t6_partial_nwin", n_win, 0);
        load_ramp(1);
        run_stream(0, 100, 1'b0);
        check_val("t6_nwin", n_win, 6);
        check_ramp_win("t6_first", 0, 0, 0, 1'b0);
        check_ramp_win("t6_final", 5, 1, 2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
